// File: rtl/aux_irq_pkg.sv
// Shared constants for the auxiliary-input interrupt detect stage.
// The optional debounce filter is compiled in with AUX_DEBOUNCE_EN.
package aux_irq_pkg;

  localparam logic MODE_LEVEL    = 1'b0;
  localparam logic MODE_EDGE     = 1'b1;
  localparam logic POL_LOW_FALL  = 1'b0;
  localparam logic POL_HIGH_RISE = 1'b1;

  localparam int DEFAULT_W         = 32;
  localparam int DEFAULT_DB_CYCLES = 4;

endpackage

// File: rtl/aux_debounce_bit.sv
// Single-bit stability filter: the output follows the input only after the
// input has differed from it for DB_CYCLES consecutive samples.
module aux_debounce_bit
  import aux_irq_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_f
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_f;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_f   <= 1'b0;
    end else if (i_d == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_f   <= i_d;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_f = r_f;

endmodule

// File: rtl/aux_edge_irq.sv
// Per-bit edge/level event detection into a sticky W1C status register with a
// single maskable interrupt. Define AUX_DEBOUNCE_EN to filter inputs first.
module aux_edge_irq
  import aux_irq_pkg::*;
#(
  parameter int W         = DEFAULT_W,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [W-1:0] aux_i,
  input  logic [W-1:0] int_type,
  input  logic [W-1:0] int_pol,
  input  logic [W-1:0] int_both,
  input  logic [W-1:0] int_en,
  input  logic         clr_we,
  input  logic [W-1:0] clr_mask,
  output logic [W-1:0] status,
  output logic         irq
);

  logic [W-1:0] w_s;
  logic [W-1:0] w_ev;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_status_next;

  logic [W-1:0] r_prev;
  logic [W-1:0] r_status;
  logic         r_armed;
  logic         r_irq;

  if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
    $error("aux_edge_irq: DB_CYCLES out of range 2..255");
  end

`ifdef AUX_DEBOUNCE_EN
  for (genvar gi = 0; gi < W; gi++) begin : g_db
    aux_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_clk  (sys_clk),
      .i_rst_n(sys_rst),
      .i_d    (aux_i[gi]),
      .o_f    (w_s[gi])
    );
  end
`else
  assign w_s = aux_i;
`endif

  for (genvar gi = 0; gi < W; gi++) begin : g_ev
    logic w_rise;
    logic w_fall;
    logic w_edge_ev;
    logic w_level_ev;

    assign w_rise     = w_s[gi] & ~r_prev[gi];
    assign w_fall     = ~w_s[gi] & r_prev[gi];
    assign w_edge_ev  = int_both[gi] ? (w_rise | w_fall)
                      : ((int_pol[gi] == POL_HIGH_RISE) ? w_rise : w_fall);
    assign w_level_ev = (int_pol[gi] == POL_HIGH_RISE) ? w_s[gi] : ~w_s[gi];
    assign w_ev[gi]   = (int_type[gi] == MODE_EDGE) ? w_edge_ev : w_level_ev;
  end

  // Set wins over clear; nothing is detected on the arming cycle.
  assign w_clr         = {W{clr_we}} & clr_mask;
  assign w_status_next = (r_status & ~w_clr) | (r_armed ? w_ev : '0);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_armed  <= 1'b0;
      r_prev   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_prev   <= w_s;
      r_status <= w_status_next;
      r_irq    <= |(r_status & int_en);
    end
  end

  assign status = r_status;
  assign irq    = r_irq;

endmodule

// File: tb/tb_aux_edge_irq.sv
// Directed self-checking bench for aux_edge_irq (default W=32, DB_CYCLES=4).
module tb_aux_edge_irq;

  localparam int W = 32;

  logic         sys_clk;
  logic         sys_rst;
  logic [W-1:0] aux_i;
  logic [W-1:0] int_type;
  logic [W-1:0] int_pol;
  logic [W-1:0] int_both;
  logic [W-1:0] int_en;
  logic         clr_we;
  logic [W-1:0] clr_mask;
  logic [W-1:0] status;
  logic         irq;

  int checks = 0;
  int errors = 0;

  aux_edge_irq #(.W(W), .DB_CYCLES(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .aux_i   (aux_i),
    .int_type(int_type),
    .int_pol (int_pol),
    .int_both(int_both),
    .int_en  (int_en),
    .clr_we  (clr_we),
    .clr_mask(clr_mask),
    .status  (status),
    .irq     (irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst  = 1'b0;
    aux_i    = 32'hFFFF_FFFF;
    int_type = 32'hFFFF_FFFF;
    int_pol  = 32'hFFFF_FFFF;
    int_both = 32'h0;
    int_en   = 32'hFFFF_FFFF;
    clr_we   = 1'b0;
    clr_mask = 32'h0;
    step();
    step();
    checks++;
    if (status !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold status=%h irq=%b want status=0 irq=0", status, irq);
    end
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (status !== 32'h0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL arm_no_event cyc=%0d status=%h irq=%b want 0/0", i, status, irq);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_edge_rise();
    int_en = 32'h8;
    aux_i  = 32'h0;
    step();
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL fall_ignored status=%h want 00000000", status);
    end
    aux_i = 32'h8;
    step();
    checks++;
    if (status !== 32'h8 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rise_set status=%h irq=%b want 00000008/0", status, irq);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL rise_irq irq=%b want 1", irq);
    end
    clr_we = 1'b1; clr_mask = 32'h8;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL rise_clear status=%h want 00000000", status);
    end
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_drop irq=%b want 0", irq);
    end
    $display("test_edge_rise done");
  endtask

  task automatic test_level_low();
    int_type = 32'hFFFF_FFFE;
    int_pol  = 32'hFFFF_FFFE;
    int_en   = 32'h1;
    step();
    checks++;
    if (status !== 32'h1) begin
      errors++;
      $display("FAIL level_set status=%h want 00000001", status);
    end
    clr_we = 1'b1; clr_mask = 32'h1;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL level_clear_blocked status=%h irq=%b want 00000001/1", status, irq);
    end
    aux_i = 32'h9;
    clr_we = 1'b1; clr_mask = 32'h1;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL level_clear status=%h want 00000000", status);
    end
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL level_irq_drop irq=%b want 0", irq);
    end
    $display("test_level_low done");
  endtask

  task automatic test_both_edges();
    int_type = 32'hFFFF_FFFF;
    int_pol  = 32'hFFFF_FFFF;
    int_both = 32'h80;
    int_en   = 32'h80;
    aux_i = 32'h89;
    step();
    checks++;
    if (status !== 32'h80) begin
      errors++;
      $display("FAIL both_rise status=%h want 00000080", status);
    end
    clr_we = 1'b1; clr_mask = 32'h80;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL both_clear status=%h irq=%b want 00000000/1", status, irq);
    end
    aux_i = 32'h09;
    step();
    checks++;
    if (status !== 32'h80) begin
      errors++;
      $display("FAIL both_fall status=%h want 00000080", status);
    end
    clr_we = 1'b1; clr_mask = 32'h80;
    step();
    clr_we = 1'b0;
    aux_i = 32'h89;
    clr_we = 1'b1; clr_mask = 32'h80;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h80) begin
      errors++;
      $display("FAIL both_set_wins status=%h want 00000080", status);
    end
    clr_we = 1'b1; clr_mask = 32'h80;
    step();
    clr_we = 1'b0;
    $display("test_both_edges done");
  endtask

  task automatic test_mask();
    int_both = 32'h0;
    int_en   = 32'h0;
    aux_i    = 32'h8000_008B;
    step();
    checks++;
    if (status !== 32'h8000_0002) begin
      errors++;
      $display("FAIL mask_status status=%h want 80000002", status);
    end
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_irq_off irq=%b want 0", irq);
    end
    int_en = 32'h2;
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL mask_irq_on irq=%b want 1", irq);
    end
    int_en = 32'h0;
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_irq_drop irq=%b want 0", irq);
    end
    clr_we = 1'b1; clr_mask = 32'hFFFF_FFFF;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL mask_clear_all status=%h want 00000000", status);
    end
    $display("test_mask done");
  endtask

  task automatic test_mode_change();
    int_type = 32'hFFFF_FFEF;
    step();
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL mode_level_high_idle status=%h want 00000000", status);
    end
    int_pol = 32'hFFFF_FFEF;
    step();
    checks++;
    if (status !== 32'h10) begin
      errors++;
      $display("FAIL mode_level_low status=%h want 00000010", status);
    end
    int_type = 32'hFFFF_FFFF;
    int_pol  = 32'hFFFF_FFFF;
    clr_we = 1'b1; clr_mask = 32'h10;
    step();
    clr_we = 1'b0;
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL mode_back_to_edge status=%h want 00000000", status);
    end
    $display("test_mode_change done");
  endtask

  task automatic test_reset_mid();
    int_en = 32'h4;
    aux_i  = 32'h8000_008F;
    step();
    step();
    checks++;
    if (status !== 32'h4 || irq !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre status=%h irq=%b want 00000004/1", status, irq);
    end
    sys_rst = 1'b0;
    #1;
    checks++;
    if (status !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear status=%h irq=%b want 0/0", status, irq);
    end
    aux_i = 32'hFFFF_FFFF;
    int_en = 32'hFFFF_FFFF;
    step();
    sys_rst = 1'b1;
    step();
    step();
    checks++;
    if (status !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_rearm status=%h irq=%b want 0/0", status, irq);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_debounce();
    sys_rst  = 1'b0;
    aux_i    = 32'h0;
    int_type = 32'hFFFF_FFFF;
    int_pol  = 32'hFFFF_FFFF;
    int_both = 32'h0;
    int_en   = 32'h20;
    clr_we   = 1'b0;
    clr_mask = 32'h0;
    step();
    sys_rst = 1'b1;
    step();
    aux_i = 32'h20;
    for (int i = 0; i < 3; i++) step();
    aux_i = 32'h0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL db_glitch status=%h want 00000000", status);
    end
    aux_i = 32'h20;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL db_early status=%h want 00000000", status);
    end
    step();
    checks++;
    if (status !== 32'h20) begin
      errors++;
      $display("FAIL db_stable status=%h want 00000020", status);
    end
    sys_rst = 1'b0;
    aux_i = 32'h0;
    step();
    sys_rst = 1'b1;
    step();
    aux_i = 32'h20;
    for (int i = 0; i < 3; i++) step();
    sys_rst = 1'b0;
    #1;
    sys_rst = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL db_reset_mid_count status=%h want 00000000", status);
    end
    step();
    checks++;
    if (status !== 32'h20) begin
      errors++;
      $display("FAIL db_after_reset status=%h want 00000020", status);
    end
    $display("test_debounce done");
  endtask

  initial begin
`ifdef AUX_DEBOUNCE_EN
    test_reset();
    test_debounce();
`else
    test_reset();
    test_edge_rise();
    test_level_low();
    test_both_edges();
    test_mask();
    test_mode_change();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
